// File: rtl/conv_line_engine.sv
// Row convolution engine: streams image rows through a (2R+1)-tap sliding window,
// hands the window to an external kernel and writes the result to the buffer SRAM.
module conv_line_engine #(
  parameter int PIX_W = 8,
  parameter int R     = 5,
  parameter int DIM_W = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic [DIM_W-1:0]         nrows,
  input  logic [DIM_W-1:0]         ncols,
  input  logic [1:0]               border_mode,
  input  logic                     transpose,
  output logic                     busy,
  output logic                     done,
  output logic                     cfg_err,
  output logic                     img_rd_en,
  output logic [DIM_W-1:0]         img_rd_row,
  output logic [DIM_W-1:0]         img_rd_col,
  input  logic [PIX_W-1:0]         img_rd_data,
  output logic [(2*R+1)*PIX_W-1:0] win,
  input  logic [PIX_W-1:0]         kern_result,
  output logic                     buf_wr_en,
  output logic [DIM_W-1:0]         buf_row,
  output logic [DIM_W-1:0]         buf_col,
  output logic [PIX_W-1:0]         buf_wr_data,
  output logic [1:0]               dbg_state
);

  localparam int TAPS  = 2 * R + 1;
  localparam int WIN_W = TAPS * PIX_W;
  localparam int CW    = DIM_W + 2;

  localparam logic signed [CW-1:0] R_S   = CW'(R);
  localparam logic signed [CW-1:0] NEG_R = CW'(-R);
  localparam logic signed [CW-1:0] ONE_S = CW'(1);
  localparam logic [DIM_W-1:0]     R_D   = DIM_W'(R);
  localparam logic [DIM_W-1:0]     ONE_D = DIM_W'(1);
  localparam logic [DIM_W-1:0]     ZERO_D = '0;

  localparam logic [1:0] MODE_MIRROR = 2'd0;
  localparam logic [1:0] MODE_REPL   = 2'd1;
  localparam logic [1:0] MODE_ZERO   = 2'd2;
  localparam logic [1:0] MODE_RSVD   = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t state, state_nxt;

  logic [DIM_W-1:0]     nrows_q, ncols_q, row_q;
  logic [1:0]           mode_q;
  logic                 transpose_q, cfg_err_q, drain_q;
  logic signed [CW-1:0] v_q, ncols_s, v_last;
  logic [DIM_W-1:0]     v_lo, pc;
  logic                 oob_lo, oob_hi, zero_slot;
  logic                 start_ok, cfg_bad, row_end, last_row;

  logic                 s1_valid, s1_zero, s1_wr;
  logic [DIM_W-1:0]     s1_col, s1_row;
  logic                 s2_wr;
  logic [DIM_W-1:0]     s2_col, s2_row;

  // Handshake: start is a one-cycle request honoured only in IDLE; the frame
  // ends with a one-cycle done pulse, with busy covering start+1 .. done.
  assign start_ok = (state == S_IDLE) && start;
  assign cfg_bad  = (nrows == ZERO_D) || (ncols == ZERO_D) || (border_mode == MODE_RSVD) ||
                    ((border_mode == MODE_MIRROR) && (ncols <= R_D));

  assign ncols_s  = {2'b00, ncols_q};
  assign v_last   = ncols_s + R_S - ONE_S;
  assign v_lo     = v_q[DIM_W-1:0];
  assign oob_lo   = v_q[CW-1];
  assign oob_hi   = (v_q >= ncols_s);
  assign row_end  = (v_q == v_last);
  assign last_row = (row_q == nrows_q - ONE_D);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = cfg_bad ? S_DONE : S_RUN;
      S_RUN:   if (row_end && last_row) state_nxt = S_DRAIN;
      S_DRAIN: if (drain_q) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      nrows_q     <= '0;
      ncols_q     <= '0;
      mode_q      <= '0;
      transpose_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      row_q       <= '0;
      v_q         <= '0;
      drain_q     <= 1'b0;
    end else if (start_ok) begin
      nrows_q     <= nrows;
      ncols_q     <= ncols;
      mode_q      <= border_mode;
      transpose_q <= transpose;
      cfg_err_q   <= cfg_bad;
      row_q       <= '0;
      v_q         <= NEG_R;
      drain_q     <= 1'b0;
    end else if (state == S_RUN) begin
      // Rows run back-to-back: the slot after a row's last one is v=-R of the next row.
      if (row_end) begin
        v_q   <= NEG_R;
        row_q <= row_q + ONE_D;
      end else begin
        v_q <= v_q + ONE_S;
      end
    end else if (state == S_DRAIN) begin
      drain_q <= 1'b1;
    end
  end

  // Virtual column to physical column; arithmetic is mod 2^DIM_W, results are in range.
  always_comb begin
    pc        = v_lo;
    zero_slot = 1'b0;
    if (oob_lo || oob_hi) begin
      case (mode_q)
        MODE_MIRROR: pc = oob_lo ? (ZERO_D - v_lo) : (((ncols_q - ONE_D) << 1) - v_lo);
        MODE_REPL:   pc = oob_lo ? ZERO_D : (ncols_q - ONE_D);
        default: begin
          pc        = ZERO_D;
          zero_slot = (mode_q == MODE_ZERO);
        end
      endcase
    end
  end

  assign img_rd_en  = (state == S_RUN) && !zero_slot;
  assign img_rd_row = (state == S_RUN) ? row_q : ZERO_D;
  assign img_rd_col = img_rd_en ? pc : ZERO_D;

  // Stage 1 tracks the slot whose data returns this cycle; stage 2 the slot to write.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_zero  <= 1'b0;
      s1_wr    <= 1'b0;
      s1_col   <= '0;
      s1_row   <= '0;
      s2_wr    <= 1'b0;
      s2_col   <= '0;
      s2_row   <= '0;
      win      <= '0;
    end else begin
      s1_valid <= (state == S_RUN);
      s1_zero  <= zero_slot;
      s1_wr    <= (v_q >= R_S);
      s1_col   <= v_lo - R_D;
      s1_row   <= row_q;
      s2_wr    <= s1_valid && s1_wr;
      s2_col   <= s1_col;
      s2_row   <= s1_row;
      if (s1_valid)
        win <= {(s1_zero ? {PIX_W{1'b0}} : img_rd_data), win[WIN_W-1:PIX_W]};
    end
  end

  assign buf_wr_en   = s2_wr;
  assign buf_row     = !s2_wr ? ZERO_D : (transpose_q ? s2_col : s2_row);
  assign buf_col     = !s2_wr ? ZERO_D : (transpose_q ? s2_row : s2_col);
  assign buf_wr_data = kern_result;

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign cfg_err   = cfg_err_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_conv_line_engine.sv
// Bench for conv_line_engine (R=2): SRAM model, selectable-tap kernel, write scoreboard.
module tb_conv_line_engine;

  localparam int PIX_W = 8;
  localparam int R     = 2;
  localparam int DIM_W = 8;
  localparam int TAPS  = 2 * R + 1;

  logic                    clk, rstn, start, transpose;
  logic [DIM_W-1:0]        nrows, ncols;
  logic [1:0]              border_mode;
  logic                    busy, done, cfg_err, img_rd_en, buf_wr_en;
  logic [DIM_W-1:0]        img_rd_row, img_rd_col, buf_row, buf_col;
  logic [PIX_W-1:0]        img_rd_data, kern_result, buf_wr_data;
  logic [TAPS*PIX_W-1:0]   win;
  logic [1:0]              dbg_state;

  int total = 0;
  int bad   = 0;
  int kern_sel = R;
  logic [23:0] exp_q[$];
  logic [23:0] mon_e;

  conv_line_engine #(.PIX_W(PIX_W), .R(R), .DIM_W(DIM_W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .nrows(nrows), .ncols(ncols),
    .border_mode(border_mode), .transpose(transpose), .busy(busy), .done(done),
    .cfg_err(cfg_err), .img_rd_en(img_rd_en), .img_rd_row(img_rd_row),
    .img_rd_col(img_rd_col), .img_rd_data(img_rd_data), .win(win),
    .kern_result(kern_result), .buf_wr_en(buf_wr_en), .buf_row(buf_row),
    .buf_col(buf_col), .buf_wr_data(buf_wr_data), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- environment models ----------------
  function automatic logic [7:0] pix(input int r, input int c);
    return 8'((16 * r + c) & 255);
  endfunction

  always @(posedge clk)
    if (img_rd_en) img_rd_data <= pix(int'(img_rd_row), int'(img_rd_col));

  assign kern_result = win[kern_sel*PIX_W +: PIX_W];

  function automatic logic [7:0] ref_pix(input int r, input int v, input int nc, input int mode);
    int pc;
    if (v >= 0 && v < nc) pc = v;
    else if (mode == 2)   return 8'h00;
    else if (mode == 0)   pc = (v < 0) ? -v : 2 * (nc - 1) - v;
    else                  pc = (v < 0) ? 0 : nc - 1;
    return pix(r, pc);
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, expv);
    end
  endtask

  always @(negedge clk) begin
    if (rstn && buf_wr_en) begin
      if (exp_q.size() == 0) begin
        check("wr_unexpected", {8'h00, buf_row, buf_col, buf_wr_data}, 32'hffffffff);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr", {8'h00, buf_row, buf_col, buf_wr_data}, {8'h00, mon_e});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_frame(input int nr, input int nc, input int mode, input bit tr, input int ksel);
    logic [7:0] d;
    for (int r = 0; r < nr; r++)
      for (int c = 0; c < nc; c++) begin
        d = ref_pix(r, c - R + ksel, nc, mode);
        if (tr) exp_q.push_back({8'(c), 8'(r), d});
        else    exp_q.push_back({8'(r), 8'(c), d});
      end
  endtask

  task automatic run_frame(input int nr, input int nc, input int mode, input bit tr,
                           input int ksel, input int mid_start);
    int n, big_n, rd, wr, first_wr, last_rd, oob, exp_rd;
    bit seen_done, err_exp;
    err_exp  = (nr == 0) || (nc == 0) || (mode == 3) || (mode == 0 && nc <= R);
    big_n    = err_exp ? 1 : nr * (nc + 2 * R) + 3;
    exp_rd   = err_exp ? 0 : ((mode == 2) ? nr * nc : nr * (nc + 2 * R));
    kern_sel = ksel;
    if (!err_exp) push_frame(nr, nc, mode, tr, ksel);
    @(negedge clk);
    nrows = 8'(nr); ncols = 8'(nc); border_mode = 2'(mode); transpose = tr;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1; rd = 0; wr = 0; first_wr = -1; last_rd = -1; oob = 0; seen_done = 0;
    while (!seen_done && n <= big_n + 20) begin
      start = (n == mid_start);
      if (img_rd_en) begin
        rd++;
        last_rd = n;
        if (int'(img_rd_col) >= nc || int'(img_rd_row) >= nr) oob++;
      end
      if (mode == 2 && !err_exp && n <= R) check("zero_lead_rd_en", img_rd_en, 0);
      if (buf_wr_en) begin
        wr++;
        if (first_wr < 0) first_wr = n;
      end
      if (done) begin
        seen_done = 1;
        check("done_cycle", n, big_n);
        check("busy_at_done", busy, 1);
        check("cfg_err_at_done", cfg_err, err_exp);
      end else begin
        @(negedge clk);
        n++;
      end
    end
    start = 1'b0;
    if (!seen_done) check("done_timeout", 0, 1);
    @(negedge clk);
    check("busy_after_done", busy, 0);
    check("done_pulse_width", done, 0);
    check("rd_count", rd, exp_rd);
    check("rd_addr_range", oob, 0);
    check("wr_count", wr, err_exp ? 0 : nr * nc);
    if (!err_exp) check("first_wr_cycle", first_wr, 2 * R + 3);
    if (!err_exp && mode != 2) check("last_rd_cycle", last_rd, big_n - 3);
    check("sb_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic reset_mid_frame();
    bit found, io_seen, done_seen;
    kern_sel = R;
    push_frame(4, 6, 0, 0, R);
    @(negedge clk);
    nrows = 8'd4; ncols = 8'd6; border_mode = 2'd0; transpose = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (img_rd_en && img_rd_row == 8'd1 && img_rd_col == 8'd3) found = 1;
      else @(negedge clk);
    end
    if (!found) check("rst_find_row1_timeout", 0, 1);
    #2 rstn = 1'b0;
    #1;
    check("rst_async_ctrl", {busy, done, cfg_err, img_rd_en, buf_wr_en, dbg_state}, 0);
    check("rst_async_addr", {img_rd_row, img_rd_col, buf_row, buf_col}, 0);
    check("rst_async_win_zero", (win == '0), 1);
    exp_q.delete();
    io_seen = 0; done_seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 5) rstn = 1'b1;
      if (done) done_seen = 1;
      if (img_rd_en || buf_wr_en) io_seen = 1;
    end
    check("rst_no_done", done_seen, 0);
    check("rst_no_io", io_seen, 0);
    check("rst_idle_state", {busy, dbg_state}, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rstn = 1'b0; start = 1'b0; nrows = '0; ncols = '0; border_mode = '0; transpose = 1'b0;
    #12;
    check("reset_ctrl", {busy, done, cfg_err, img_rd_en, buf_wr_en, dbg_state}, 0);
    check("reset_addr", {img_rd_row, img_rd_col, buf_row, buf_col}, 0);
    check("reset_win_zero", (win == '0), 1);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("idle_after_reset", {busy, done, dbg_state}, 0);

    run_frame(4, 6, 0, 0, R, 0);  // mirror, centre tap: buffer equals image
    run_frame(4, 6, 0, 0, 0, 0);  // mirror, tap 0
    run_frame(4, 6, 1, 0, 0, 0);  // replicate, tap 0
    run_frame(4, 6, 2, 0, 0, 0);  // zero, tap 0
    run_frame(3, 5, 0, 1, R, 0);  // transposed
    run_frame(4, 2, 0, 0, R, 0);  // ncols <= R in mirror: rejected
    run_frame(4, 6, 1, 0, 4, 0);  // valid start clears cfg_err
    run_frame(2, 6, 3, 0, R, 0);  // reserved border mode
    run_frame(0, 6, 1, 0, R, 0);  // zero rows
    run_frame(3, 0, 2, 0, R, 0);  // zero columns
    run_frame(4, 6, 0, 0, 1, 15); // start pulsed mid-frame is ignored
    run_frame(2, 40, 1, 0, 3, 0); // long rows back-to-back
    for (int i = 0; i < 4; i++)
      run_frame($urandom_range(1, 3), $urandom_range(3, 12), $urandom_range(0, 2),
                1'($urandom_range(0, 1)), $urandom_range(0, TAPS - 1), 0);
    reset_mid_frame();
    run_frame(2, 5, 0, 0, R, 0);  // clean frame after the abort

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_line_engine.md
Name: conv_line_engine

Overview:
- Parametrised successor to the single-radius row convolution controller.
- Streams each image row from the image SRAM through a (2R+1)-tap sliding window, presents the window to an external kernel datapath, and writes the kernel result to the buffer SRAM, optionally transposed.
- Adds a start/done handshake instead of rstn-held enable, selectable border mode (mirror/replicate/zero), and configuration checking.
- Rows are pipelined back-to-back with no inter-row bubble.

Parameters:
- PIX_W, 8, pixel width in bits.
- R, 5, kernel radius; window has 2R+1 taps; legal range 1..7.
- DIM_W, 8, width of row/column dimensions and addresses.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle start pulse; honoured only when idle.
- nrows  in  DIM_W  row count; sampled on accepted start.
- ncols  in  DIM_W  column count; sampled on accepted start.
- border_mode  in  2  0=mirror, 1=replicate, 2=zero, 3=reserved (treated as error); sampled on start.
- transpose  in  1  1 = swap row/col on buffer writes; sampled on start.
- busy  out  1  high from the cycle after accepted start through the done cycle.
- done  out  1  one-cycle pulse at frame end.
- cfg_err  out  1  set with done when the configuration was rejected; held until the next accepted start.
- img_rd_en  out  1  image SRAM read strobe.
- img_rd_row  out  DIM_W  image read row.
- img_rd_col  out  DIM_W  image read column.
- img_rd_data  in  PIX_W  read data, valid the cycle after img_rd_en.
- win  out  (2R+1)*PIX_W  window; tap 0 = leftmost (oldest) pixel in bits [PIX_W-1:0]; tap R = centre.
- kern_result  in  PIX_W  combinational kernel output for the current win.
- buf_wr_en  out  1  buffer SRAM write strobe.
- buf_row  out  DIM_W  buffer write row.
- buf_col  out  DIM_W  buffer write column.
- buf_wr_data  out  PIX_W  equals kern_result.

Behaviour:
- Reset values: busy=0, done=0, cfg_err=0, img_rd_en=0, buf_wr_en=0, win all 0, all address outputs 0. FSM returns to IDLE.
- FSM: IDLE -> RUN on start (valid config) -> DRAIN -> DONE -> IDLE.
- Invalid config on start: go IDLE -> DONE with cfg_err=1. Invalid means nrows=0, ncols=0, ncols<=R in mirror mode, ncols=0 otherwise, or border_mode=3. No reads and no writes are issued.
- Start while busy is ignored.
- RUN, per row r: issue one read slot per cycle for virtual column v = -R .. ncols-1+R, i.e. ncols+2R slots. Use a signed counter of DIM_W+2 bits.
- Physical column mapping:
  - mirror: v<0 -> -v; v>=ncols -> 2(ncols-1)-v. The edge pixel is not repeated.
  - replicate: clamp v to 0..ncols-1.
  - zero: out-of-range slots drive img_rd_en=0 and shift a 0 into the window in place of data.
- Pipeline: a slot issued in cycle t returns data in t+1 and is shifted into tap 2R at the end of t+1. Taps move toward tap 0.
- Write rule: in cycle t+2, if slot index k = v+R >= 2R, assert buf_wr_en with output column k-2R, row r, and buf_wr_data = kern_result.
- Each row therefore yields exactly ncols writes, at columns 0..ncols-1 in order.
- Transpose: when transpose=1, buf_row = column and buf_col = row.
- Row advance: after slot v = ncols-1+R of row r, the next cycle issues v=-R of row r+1. The window is not cleared between rows, because 2R fresh shifts precede the next write.
- After the last slot of row nrows-1, enter DRAIN for 2 cycles to complete the final shifts and writes, then DONE. done=1 for one cycle, busy=1 in that cycle, and busy=0 the next cycle.
- Timing: frame length from start to done is nrows*(ncols+2R)+3 cycles. The first write occurs 2R+3 cycles after start.
- Reset mid-frame: aborts immediately. No further reads or writes; done is not asserted.

Test Plan:
- R=2, 4x6 ramp image (pixel=16r+c), mirror, kern_result=win centre tap -> buffer equals the image exactly; 24 writes; done at cycle 4*10+3 after start.
- Same image, R=2, kern_result=tap 0 -> row 0 writes 2,1,0,1,2,3 (mirror); replicate mode gives 0,0,0,1,2,3; zero mode gives 0,0,0,1,2,3 with img_rd_en low on the 2 leading slots.
- transpose=1, 3x5 image -> write to (c,r) for every pixel; no write ever has buf_row >= 5 or buf_col >= 3.
- ncols=2, R=2, mirror -> done plus cfg_err the cycle after start, no img_rd_en or buf_wr_en. Then start with a valid config -> cfg_err clears and the frame completes.
- Start pulsed mid-frame -> ignored, with an identical write trace. Assert rstn low mid-row 1 -> all outputs reach their reset values asynchronously, and no done pulse occurs.
- R=7, PIX_W=10, DIM_W=9, 2x300 image, replicate, back-to-back rows -> no bubble: read slots are contiguous across the row boundary; 600 writes.
